// File: rtl/cdc_toggle_rx_mc.sv
// Multi-channel toggle-handshake receiver: synchronises request toggles, arbitrates round-robin, returns ack toggles.
// Define CDC_TOGGLE_RX_ERR_EN to latch sticky per-channel violation flags on dest_err.
module cdc_toggle_rx_mc #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              dest_clk,
  input  logic              dest_reset_n,
  input  logic [NUM_CH-1:0] src_req_tgl,
  output logic [NUM_CH-1:0] dest_ack_tgl,
  output logic              dest_strobe,
  output logic [CW-1:0]     dest_ch,
  input  logic              dest_stall,
  output logic [NUM_CH-1:0] dest_err
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] hist_q;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [NUM_CH-1:0] busy, edge_det, gnt_oh, acc_oh;
  logic              strobe_q, strobe_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     gnt_idx, rr_nxt;
  logic              gnt_valid, load, accept;

  assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

  // A channel stays busy until its event is accepted; edges in that window are violations.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_busy
    assign busy[gi] = pend_q[gi] | (strobe_q & (ch_q == CW'(gi)));
  end

  // Scan downward from rr_q+NUM_CH-1 so the lowest index at or after rr_q wins last.
  always_comb begin
    int          idx;
    logic [CW-1:0] sel;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      sel = CW'(idx);
      if (pend_q[sel]) begin
        gnt_valid = 1'b1;
        gnt_idx   = sel;
      end
    end
  end

  assign rr_nxt = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + CW'(1);
  assign accept = strobe_q & ~dest_stall;
  assign load   = gnt_valid & (~strobe_q | ~dest_stall);
  assign gnt_oh = NUM_CH'(1) << gnt_idx;
  assign acc_oh = NUM_CH'(1) << ch_q;

  always_comb begin
    pend_d   = (pend_q | (edge_det & ~busy)) & ~(load ? gnt_oh : '0);
    ack_d    = ack_q ^ (accept ? acc_oh : '0);
    strobe_d = load ? 1'b1 : (accept ? 1'b0 : strobe_q);
    ch_d     = load ? gnt_idx : ch_q;
    rr_d     = load ? rr_nxt : rr_q;
  end

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q   <= '0;
      pend_q   <= '0;
      ack_q    <= '0;
      strobe_q <= 1'b0;
      ch_q     <= '0;
      rr_q     <= '0;
    end else begin
      sync_q[0] <= src_req_tgl;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q   <= sync_q[SYNC_STAGES-1];
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      strobe_q <= strobe_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
    end
  end

  assign dest_ack_tgl = ack_q;
  assign dest_strobe  = strobe_q;
  assign dest_ch      = ch_q;

`ifdef CDC_TOGGLE_RX_ERR_EN
  logic [NUM_CH-1:0] err_q;

  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) err_q <= '0;
    else               err_q <= err_q | (edge_det & busy);
  end

  assign dest_err = err_q;
`else
  assign dest_err = '0;
`endif

endmodule

// File: tb/tb_cdc_toggle_rx_mc.sv
// Scoreboard bench for cdc_toggle_rx_mc: stimulus pushes expected channels, a monitor pops them on accepted strobes.
module tb_cdc_toggle_rx_mc;

  logic       clk;
  logic       rst_n;
  logic [3:0] src;
  logic [3:0] ack;
  logic       strobe;
  logic [1:0] ch;
  logic       stall;
  logic [3:0] err;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  cdc_toggle_rx_mc dut (
    .dest_clk     (clk),
    .dest_reset_n (rst_n),
    .src_req_tgl  (src),
    .dest_ack_tgl (ack),
    .dest_strobe  (strobe),
    .dest_ch      (ch),
    .dest_stall   (stall),
    .dest_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts edges from the current point until dest_strobe is seen high.
  task automatic wait_strobe(input string name, output int n);
    n = 0;
    while (!strobe && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!strobe) check({name, "_timeout"}, {31'd0, strobe}, 32'd1);
  endtask

  // Monitor: pops on every accepted strobe, tracks ack toggles and stall stability.
  initial begin : monitor
    logic [3:0] ack_model;
    logic       ack_chk;
    logic       stalled_prev;
    logic [1:0] ch_prev;
    int         exp_ch;
    ack_model    = '0;
    ack_chk      = 1'b0;
    stalled_prev = 1'b0;
    ch_prev      = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_model    = '0;
        ack_chk      = 1'b0;
        stalled_prev = 1'b0;
      end else begin
        if (ack_chk) begin
          check("ack_tgl", {28'd0, ack}, {28'd0, ack_model});
          ack_chk = 1'b0;
        end
        if (stalled_prev) begin
          check("stall_hold_strobe", {31'd0, strobe}, 32'd1);
          check("stall_hold_ch", {30'd0, ch}, {30'd0, ch_prev});
        end
        stalled_prev = 1'b0;
        if (strobe) begin
          if (stall) begin
            stalled_prev = 1'b1;
            ch_prev      = ch;
          end else begin
            if (exp_q.size() == 0) begin
              check("unexpected_event_ch", {30'd0, ch}, 32'hFFFF_FFFF);
            end else begin
              exp_ch = exp_q.pop_front();
              check("event_ch", {30'd0, ch}, exp_ch);
            end
            ack_model[ch] = ~ack_model[ch];
            ack_chk       = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int         n;
    logic [3:0] ack_before;
    rst_n = 1'b0;
    src   = 4'b0000;
    stall = 1'b0;
    tick(3);
    check("reset_strobe", {31'd0, strobe}, 32'd0);
    check("reset_ch", {30'd0, ch}, 32'd0);
    check("reset_ack", {28'd0, ack}, 32'd0);
    check("reset_err", {28'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3);

    // Single event on channel 2: strobe after edge 4, one cycle long.
    src[2] = 1'b1;
    exp_q.push_back(2);
    wait_strobe("lat", n);
    check("latency_edges", n, 32'd4);
    check("lat_ch", {30'd0, ch}, 32'd2);
    tick(1);
    check("single_cycle_strobe", {31'd0, strobe}, 32'd0);
    tick(4);

    // Channel 3 alone moves rr_ptr to 0 ahead of the burst.
    src[3] = 1'b1;
    exp_q.push_back(3);
    tick(8);

    // Burst on 0,1,3: three back-to-back strobes.
    src = src ^ 4'b1011;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    wait_strobe("burst", n);
    n = 0;
    while (strobe && n < 10) begin
      n++;
      tick(1);
    end
    check("burst_len", n, 32'd3);
    tick(4);
    check("burst_queue_empty", exp_q.size(), 32'd0);

    // Channel 1 under a 5-cycle stall.
    stall  = 1'b1;
    src[1] = ~src[1];
    exp_q.push_back(1);
    wait_strobe("stall", n);
    ack_before = ack;
    tick(5);
    check("stall_ack_stable", {28'd0, ack}, {28'd0, ack_before});
    check("stall_strobe", {31'd0, strobe}, 32'd1);
    check("stall_ch", {30'd0, ch}, 32'd1);
    stall = 1'b0;
    tick(6);
    check("stall_queue_empty", exp_q.size(), 32'd0);

    // Double toggle on channel 0 while stalled: one event, violation on channel 0.
    stall  = 1'b1;
    src[0] = ~src[0];
    exp_q.push_back(0);
    tick(1);
    src[0] = ~src[0];
    tick(8);
`ifdef CDC_TOGGLE_RX_ERR_EN
    check("viol_err", {28'd0, err}, 32'h1);
`else
    check("viol_err", {28'd0, err}, 32'h0);
`endif
    stall = 1'b0;
    tick(8);
    check("viol_queue_empty", exp_q.size(), 32'd0);

    // Reset asynchronously with one event stalled and two pending.
    stall = 1'b1;
    src   = src ^ 4'b1110;
    wait_strobe("pre_reset", n);
    tick(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_strobe", {31'd0, strobe}, 32'd0);
    check("async_rst_ch", {30'd0, ch}, 32'd0);
    check("async_rst_ack", {28'd0, ack}, 32'd0);
    check("async_rst_err", {28'd0, err}, 32'd0);
    src   = 4'b0101;
    stall = 1'b0;
    tick(2);
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(12);
    check("post_reset_queue_empty", exp_q.size(), 32'd0);
    check("post_reset_ack", {28'd0, ack}, 32'h5);

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
